// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the multi-port register file:
//   - rf_state_t     : clear-sequencer states (INIT clears the array, RUN is normal use)
//   - XLEN_DEF       : default data width
//   - NREGS_DEF      : default register count
//   - MATCH_W        : width of the match vector accepted by wr_pick (upper bound on NWR)
//   - wr_pick        : returns the highest set index of a write-match vector
package regfile_pkg;

    typedef enum logic {
        INIT,
        RUN
    } rf_state_t;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned MATCH_W   = 32;

    // Higher write-port index has priority, so the last set bit wins.
    // Returns 0 when no bit is set; callers qualify with the OR of the vector.
    function automatic logic [4:0] wr_pick(input logic [MATCH_W-1:0] match);
        logic [4:0] sel;
        sel = '0;
        for (int unsigned i = 0; i < MATCH_W; i++) begin
            if (match[i]) begin
                sel = 5'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Busy-bit scoreboard for pipeline hazard detection.
//   Ports:
//     clk, rst    : clock, asynchronous active-high reset
//     wr_en       : per-port write enables (already qualified by the caller)
//     wr_addr     : per-port write addresses, port i at [i*AW +: AW]
//     alloc_en    : issue allocates a destination (already qualified)
//     alloc_addr  : destination being allocated
//     busy        : one busy bit per register, bit 0 always 0
//     alloc_waw   : registered, previous cycle allocated an already-busy register
module regfile_scoreboard #(
    parameter  int unsigned NREGS = 32,
    parameter  int unsigned NWR   = 2,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr,
    output logic [NREGS-1:0]  busy,
    output logic              alloc_waw
);

    logic [NREGS-1:0] busy_next;

    // Clears are applied first and the allocation last, so a same-cycle
    // allocation of a register being written leaves it busy.
    always_comb begin
        busy_next = busy;
        for (int unsigned i = 0; i < NWR; i++) begin
            if (wr_en[i]) begin
                busy_next[wr_addr[i*AW +: AW]] = 1'b0;
            end
        end
        if (alloc_en) begin
            busy_next[alloc_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= '0;
            alloc_waw <= 1'b0;
        end else begin
            busy      <= busy_next;
            alloc_waw <= alloc_en && (alloc_addr != '0) && busy[alloc_addr];
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb
//   Parametrised multi-port register file with same-cycle write-to-read bypass,
//   busy-bit scoreboard, sequenced post-reset clear and a debug tap.
//   Ports:
//     clk, rst    : clock, asynchronous active-high reset
//     ready       : high once the post-reset clear has completed
//     rd_addr     : read addresses, port p at [p*AW +: AW]
//     rd_data     : read data (combinational, with bypass), port p at [p*XLEN +: XLEN]
//     rd_busy     : selected register has an outstanding producer
//     wr_en       : write enables, higher index has priority
//     wr_addr     : write addresses, port i at [i*AW +: AW]
//     wr_data     : write data, port i at [i*XLEN +: XLEN]
//     alloc_en    : issue marks alloc_addr busy
//     alloc_addr  : destination register being allocated
//     alloc_waw   : registered, previous cycle allocated an already-busy register
//     dbg_addr    : debug tap select
//     dbg_data    : array[dbg_addr], no bypass, 0 while clearing
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 2,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    output logic                alloc_waw,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data
);

    rf_state_t        state;
    logic [AW-1:0]    cnt;
    logic             run;
    logic [XLEN-1:0]  mem [NREGS];

    logic [NWR-1:0]   wr_en_run;
    logic             alloc_en_run;
    logic [AW-1:0]    wa [NWR];
    logic [XLEN-1:0]  wd [NWR];
    logic [NREGS-1:0] busy;

    assign run          = (state == RUN);
    assign wr_en_run    = wr_en & {NWR{run}};
    assign alloc_en_run = alloc_en && run;

    always_comb begin
        for (int unsigned i = 0; i < NWR; i++) begin
            wa[i] = wr_addr[i*AW +: AW];
            wd[i] = wr_data[i*XLEN +: XLEN];
        end
    end

    // Clear sequencer: one register per cycle, ready after NREGS edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(NREGS - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    // Array has no reset; the clear sequencer zeroes it instead. Ascending
    // port order lets the last non-blocking write (highest index) win.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[cnt] <= '0;
        end else begin
            for (int unsigned i = 0; i < NWR; i++) begin
                if (wr_en_run[i] && (wa[i] != '0)) begin
                    mem[wa[i]] <= wd[i];
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en_run),
        .wr_addr    (wr_addr),
        .alloc_en   (alloc_en_run),
        .alloc_addr (alloc_addr),
        .busy       (busy),
        .alloc_waw  (alloc_waw)
    );

    // Read ports: zero register, then bypass from the winning write port,
    // then the array. A bypassed operand is reported as not busy.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned p = 0; p < NRD; p++) begin
            logic [AW-1:0]      ra;
            logic [MATCH_W-1:0] match;
            logic [4:0]         sel;
            logic               hit;
            logic [XLEN-1:0]    byp;

            ra    = rd_addr[p*AW +: AW];
            match = '0;
            for (int unsigned i = 0; i < NWR; i++) begin
                match[i] = wr_en_run[i] && (wa[i] == ra);
            end
            sel = wr_pick(match);
            hit = |match;
            byp = '0;
            for (int unsigned i = 0; i < NWR; i++) begin
                if (5'(i) == sel) begin
                    byp = wd[i];
                end
            end

            if (!run || (ra == '0)) begin
                rd_data[p*XLEN +: XLEN] = '0;
            end else if (hit) begin
                rd_data[p*XLEN +: XLEN] = byp;
            end else begin
                rd_data[p*XLEN +: XLEN] = mem[ra];
            end
            rd_busy[p] = run && busy[ra] && !hit;
        end
    end

    assign dbg_data = run ? mem[dbg_addr] : '0;

endmodule
